alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Front-end issue controller for the 8-bit ALU. Accepts one operation per valid/ready handshake (opcode plus two operands) and holds the ALU's op_sel and operand inputs stable for a configurable number of cycles.
- Captures the ALU's selected result and returns it on an output valid/ready handshake.
- Tags each result with its functional class (arith/logic/cmp/shift), decoded with the same opcode map the ALU's result mux uses.
- Sits between the instruction path and the ALU core.

Parameters:
- ALU_LAT, 1, cycles from operand/op_sel launch to result sampling; legal range 1..15.
- COUNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  operation request valid.
- instr_ready  out  1  controller can accept an operation.
- instr_op  in  4  ALU opcode.
- instr_a  in  8  operand A.
- instr_b  in  8  operand B.
- alu_op_sel  out  4  registered opcode driven to the ALU.
- alu_a  out  8  registered operand A to the ALU.
- alu_b  out  8  registered operand B to the ALU.
- alu_result  in  8  ALU final result (combinational from alu_op_sel/alu_a/alu_b).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  captured result.
- res_class  out  2  class of the completed op: 0 arith, 1 logic, 2 cmp, 3 shift.
- busy  out  1  high in EXEC or DONE.
- op_count  out  COUNT_W  number of results consumed; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (async, rst_n low): state IDLE; alu_op_sel/alu_a/alu_b = 0; res_valid = 0; res_data = 0; res_class = 0; op_count = 0; wait counter = 0; busy = 0. instr_ready reads 1 as soon as rst_n deasserts.
- Reset mid-operation: the in-flight op is discarded and no result is produced.
- States: IDLE, EXEC, DONE.
- instr_ready = (state==IDLE) || (state==DONE && res_ready). Accept = instr_valid && instr_ready.
- IDLE + accept:
  - Register instr_op/a/b into alu_op_sel/alu_a/alu_b.
  - Load wait counter with ALU_LAT-1.
  - Go to EXEC.
- EXEC:
  - ALU inputs held constant; instr_ready = 0; input requests are ignored.
  - Each edge with counter != 0: decrement.
  - Edge with counter == 0: res_data <= alu_result, res_class <= class(alu_op_sel), res_valid <= 1, go to DONE.
- Latency: res_valid rises exactly ALU_LAT cycles after the accept edge (ALU_LAT=1 gives res_valid in the cycle after accept).
- DONE: res_valid, res_data and res_class are held stable until res_ready.
  - res_ready && accept: op_count++, latch the new op, go to EXEC. res_valid drops for at least ALU_LAT cycles, so there is no bubble-free overlap.
  - res_ready && !accept: op_count++, res_valid <= 0, go to IDLE. res_data/res_class keep their last values.
- Class decode (mirrors the ALU mux priority):
  - 0000-0010 and 1000 -> arith.
  - 0011-0110 -> logic.
  - 1100, 1101 -> shift.
  - 0111, 1001, 1010, 1011, 1110, 1111 -> cmp.
  - All 16 codes are legal.
- alu_op_sel/alu_a/alu_b change only on accept edges and retain the last op while IDLE.
- op_count wraps from all-ones to 0 with no flag.

Decomposition:
- Shared include alu_defs.vh holds:
  - class codes CLS_ARITH=2'd0, CLS_LOGIC=2'd1, CLS_CMP=2'd2, CLS_SHIFT=2'd3;
  - FSM state encodings;
  - named opcode constants (OP_SHL=4'b1100, OP_SHR=4'b1101, etc.).
- One natural sub-module: alu_op_classify, a combinational opcode -> res_class decoder. It is reusable by the mux and the test bench.

Test Plan:
- Reset, then ALU_LAT=1, op 0000, a=8'h05, b=8'h03, model ALU returns 8'h08 -> res_valid in cycle after accept; res_data=8'h08, res_class=0; op_count=1 after res_ready.
- All 16 opcodes issued sequentially with res_ready=1 -> classes match the decode list (1000 -> 0, 1110 -> 2, 1101 -> 3, 0100 -> 1); op_count=16.
- ALU_LAT=3, res_ready held low 5 cycles after res_valid -> res_data/res_class stable and instr_ready=0 throughout. Then res_ready=1 with instr_valid=1 -> new op accepted on the same edge and the next res_valid comes 3 cycles later.
- instr_valid pulsed during EXEC with different operands -> ignored; alu_a/alu_b unchanged; result corresponds to the first op.
- rst_n asserted in EXEC (ALU_LAT=4, cycle 2) -> outputs immediately 0, no res_valid ever for that op, op_count=0.
- COUNT_W=4, 17 completed ops -> op_count wraps to 1.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller slice.
// Holds the FSM state encoding, the result class codes, the named ALU
// opcodes and the opcode -> class decode function that mirrors the
// priority order of the ALU result mux.
package alu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CLS_ARITH = 2'd0;
    localparam logic [1:0] CLS_LOGIC = 2'd1;
    localparam logic [1:0] CLS_CMP   = 2'd2;
    localparam logic [1:0] CLS_SHIFT = 2'd3;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b0111;
    localparam logic [3:0] OP_ADC = 4'b1000;
    localparam logic [3:0] OP_LT  = 4'b1001;
    localparam logic [3:0] OP_GT  = 4'b1010;
    localparam logic [3:0] OP_LTU = 4'b1011;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_SHR = 4'b1101;
    localparam logic [3:0] OP_GTU = 4'b1110;
    localparam logic [3:0] OP_NE  = 4'b1111;

    // Every one of the 16 codes is legal; anything not arith/logic/shift
    // lands in the compare group, exactly as the ALU mux falls through.
    function automatic logic [1:0] op_class(input logic [3:0] op);
        logic [1:0] cls;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_ADC: cls = CLS_ARITH;
            OP_AND, OP_OR, OP_XOR, OP_NOT:  cls = CLS_LOGIC;
            OP_SHL, OP_SHR:                 cls = CLS_SHIFT;
            default:                        cls = CLS_CMP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_op_classify.sv
// Combinational opcode -> result class decoder.
// Ports:
//   op  - 4-bit ALU opcode
//   cls - 2-bit class: 0 arith, 1 logic, 2 cmp, 3 shift
module alu_op_classify
    import alu_issue_ctrl_pkg::*;
(
    input  logic [3:0] op,
    output logic [1:0] cls
);

    // Pure decode of the opcode into its functional class.
    always_comb begin
        cls = op_class(op);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Front-end issue controller for the 8-bit ALU.
// Accepts one op per instr valid/ready handshake, holds op_sel/operands
// stable for ALU_LAT cycles, samples the ALU result and returns it, tagged
// with its class, on the res valid/ready handshake.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   instr_valid/ready, instr_op/a/b - operation request channel
//   alu_op_sel, alu_a, alu_b        - registered ALU inputs
//   alu_result                      - combinational ALU result
//   res_valid/ready, res_data/class - result channel
//   busy                            - high while in EXEC or DONE
//   op_count                        - results consumed, wraps silently
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [3:0]         instr_op,
    input  logic [7:0]         instr_a,
    input  logic [7:0]         instr_b,
    output logic [3:0]         alu_op_sel,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    input  logic [7:0]         alu_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [7:0]         res_data,
    output logic [1:0]         res_class,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         cnt_r;
    logic [3:0]         alu_op_sel_r;
    logic [7:0]         alu_a_r;
    logic [7:0]         alu_b_r;
    logic               res_valid_r;
    logic [7:0]         res_data_r;
    logic [1:0]         res_class_r;
    logic               busy_r;
    logic [COUNT_W-1:0] op_count_r;

    logic               ready_s;
    logic               accept_s;
    logic               load_s;
    logic               capture_s;
    logic               consume_s;
    logic [1:0]         cls_s;

    alu_op_classify u_classify (
        .op  (alu_op_sel_r),
        .cls (cls_s)
    );

    // Ready is combinational on res_ready so a new op can be latched on
    // the same edge that the pending result is consumed.
    always_comb begin
        ready_s  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && res_ready);
        accept_s = instr_valid && ready_s;
    end

    // Next-state and datapath strobes for the IDLE/EXEC/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        consume_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    consume_s = 1'b1;
                    if (accept_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; busy is registered from the next state so it tracks
    // EXEC/DONE without a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand launch registers and the latency wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_sel_r <= 4'd0;
            alu_a_r      <= 8'd0;
            alu_b_r      <= 8'd0;
            cnt_r        <= 4'd0;
        end else if (load_s) begin
            alu_op_sel_r <= instr_op;
            alu_a_r      <= instr_a;
            alu_b_r      <= instr_b;
            cnt_r        <= LAT_INIT;
        end else if ((state_r == ST_EXEC) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Result capture/hold and the consumed-result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 8'd0;
            res_class_r <= 2'd0;
            op_count_r  <= '0;
        end else begin
            if (capture_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= alu_result;
                res_class_r <= cls_s;
            end else if (consume_s) begin
                // Data and class deliberately keep their last values.
                res_valid_r <= 1'b0;
            end
            if (consume_s) begin
                op_count_r <= op_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign instr_ready = ready_s;
    assign alu_op_sel  = alu_op_sel_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_class   = res_class_r;
    assign busy        = busy_r;
    assign op_count    = op_count_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl. Three instances share one clock:
// A (ALU_LAT=1), B (ALU_LAT=3), C (ALU_LAT=4, COUNT_W=4). Each instance
// has a behavioural ALU model on its alu_* outputs. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] alu_model(input logic [3:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        logic [7:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a + 8'd1;
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            4'd6:    r = ~a;
            4'd12:   r = a << b[2:0];
            4'd13:   r = a >> b[2:0];
            default: r = a ^ {op, op};
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A ----------------
    logic a_rst_n, a_iv, a_ir, a_rv, a_rr, a_busy;
    logic [3:0] a_op, a_sel;
    logic [7:0] a_a, a_b, a_aa, a_ab, a_res, a_rd;
    logic [1:0] a_rc;
    logic [15:0] a_cnt;
    assign a_res = alu_model(a_sel, a_aa, a_ab);
    alu_issue_ctrl #(.ALU_LAT(1), .COUNT_W(16)) u_a (
        .clk(clk), .rst_n(a_rst_n), .instr_valid(a_iv), .instr_ready(a_ir),
        .instr_op(a_op), .instr_a(a_a), .instr_b(a_b), .alu_op_sel(a_sel),
        .alu_a(a_aa), .alu_b(a_ab), .alu_result(a_res), .res_valid(a_rv),
        .res_ready(a_rr), .res_data(a_rd), .res_class(a_rc), .busy(a_busy),
        .op_count(a_cnt));

    // ---------------- instance B ----------------
    logic b_rst_n, b_iv, b_ir, b_rv, b_rr, b_busy;
    logic [3:0] b_op, b_sel;
    logic [7:0] b_a, b_b, b_aa, b_ab, b_res, b_rd;
    logic [1:0] b_rc;
    logic [15:0] b_cnt;
    assign b_res = alu_model(b_sel, b_aa, b_ab);
    alu_issue_ctrl #(.ALU_LAT(3), .COUNT_W(16)) u_b (
        .clk(clk), .rst_n(b_rst_n), .instr_valid(b_iv), .instr_ready(b_ir),
        .instr_op(b_op), .instr_a(b_a), .instr_b(b_b), .alu_op_sel(b_sel),
        .alu_a(b_aa), .alu_b(b_ab), .alu_result(b_res), .res_valid(b_rv),
        .res_ready(b_rr), .res_data(b_rd), .res_class(b_rc), .busy(b_busy),
        .op_count(b_cnt));

    // ---------------- instance C ----------------
    logic c_rst_n, c_iv, c_ir, c_rv, c_rr, c_busy;
    logic [3:0] c_op, c_sel;
    logic [7:0] c_a, c_b, c_aa, c_ab, c_res, c_rd;
    logic [1:0] c_rc;
    logic [3:0] c_cnt;
    assign c_res = alu_model(c_sel, c_aa, c_ab);
    alu_issue_ctrl #(.ALU_LAT(4), .COUNT_W(4)) u_c (
        .clk(clk), .rst_n(c_rst_n), .instr_valid(c_iv), .instr_ready(c_ir),
        .instr_op(c_op), .instr_a(c_a), .instr_b(c_b), .alu_op_sel(c_sel),
        .alu_a(c_aa), .alu_b(c_ab), .alu_result(c_res), .res_valid(c_rv),
        .res_ready(c_rr), .res_data(c_rd), .res_class(c_rc), .busy(c_busy),
        .op_count(c_cnt));

    // Hand-written class table, indexed by opcode.
    logic [1:0] exp_cls [16];
    int n;
    logic seen;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_cls = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                    2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
        a_rst_n = 1'b0; a_iv = 1'b0; a_rr = 1'b0; a_op = 4'd0; a_a = 8'd0; a_b = 8'd0;
        b_rst_n = 1'b0; b_iv = 1'b0; b_rr = 1'b0; b_op = 4'd0; b_a = 8'd0; b_b = 8'd0;
        c_rst_n = 1'b0; c_iv = 1'b0; c_rr = 1'b0; c_op = 4'd0; c_a = 8'd0; c_b = 8'd0;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_res_valid", a_rv, 1'b0);
        chk("rst_res_data", a_rd, 8'h00);
        chk("rst_res_class", a_rc, 2'd0);
        chk("rst_op_count", a_cnt, 16'd0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_alu_in", {a_sel, a_aa, a_ab}, 20'h0);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        #1;
        chk("rst_instr_ready", a_ir, 1'b1);

        // A: single ADD, ALU_LAT=1.
        @(negedge clk);
        a_iv = 1'b1; a_op = 4'b0000; a_a = 8'h05; a_b = 8'h03;
        @(negedge clk);
        a_iv = 1'b0;
        chk("t1_valid_early", a_rv, 1'b0);
        chk("t1_busy", a_busy, 1'b1);
        chk("t1_alu_ab", {a_aa, a_ab}, 16'h0503);
        @(negedge clk);
        chk("t1_valid", a_rv, 1'b1);
        chk("t1_data", a_rd, 8'h08);
        chk("t1_class", a_rc, 2'd0);
        a_rr = 1'b1;
        @(negedge clk);
        a_rr = 1'b0;
        chk("t1_count", a_cnt, 16'd1);
        chk("t1_valid_drop", a_rv, 1'b0);
        chk("t1_data_hold", a_rd, 8'h08);
        chk("t1_idle_busy", a_busy, 1'b0);

        // A: all 16 opcodes back to back after a fresh reset.
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        a_rr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_iv = 1'b1; a_op = 4'(i); a_a = 8'(8'h31 + 8'(i)); a_b = 8'(i + 1);
            @(negedge clk);
            a_iv = 1'b0;
            for (int k = 0; k < 8 && !a_rv; k++) @(negedge clk);
            chk($sformatf("t2_valid_op%0d", i), a_rv, 1'b1);
            chk($sformatf("t2_class_op%0d", i), a_rc, exp_cls[i]);
            chk($sformatf("t2_data_op%0d", i), a_rd,
                alu_model(4'(i), 8'(8'h31 + 8'(i)), 8'(i + 1)));
            @(negedge clk);
        end
        a_rr = 1'b0;
        chk("t2_count", a_cnt, 16'd16);

        // B: ALU_LAT=3 latency and hold while res_ready low.
        b_iv = 1'b1; b_op = 4'b0101; b_a = 8'hF0; b_b = 8'h3C;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            b_iv = 1'b0;
        end while (!b_rv && n < 20);
        chk("t3_latency", n, 4);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", b_rv, 1'b1);
            chk("t3_hold_data", b_rd, 8'hCC);
            chk("t3_hold_class", b_rc, 2'd1);
            chk("t3_hold_ready", b_ir, 1'b0);
            @(negedge clk);
        end
        b_rr = 1'b1; b_iv = 1'b1; b_op = 4'b1100; b_a = 8'h03; b_b = 8'h02;
        #1;
        chk("t3_ready_overlap", b_ir, 1'b1);
        @(negedge clk);
        b_rr = 1'b0; b_iv = 1'b0;
        chk("t3_new_sel", b_sel, 4'b1100);
        chk("t3_count", b_cnt, 16'd1);
        chk("t3_valid_drop", b_rv, 1'b0);
        n = 1;
        while (!b_rv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_latency2", n, 4);
        chk("t3_data2", b_rd, 8'h0C);
        chk("t3_class2", b_rc, 2'd3);
        b_rr = 1'b1;
        @(negedge clk);
        b_rr = 1'b0;

        // B: requests during EXEC are ignored.
        b_iv = 1'b1; b_op = 4'b0001; b_a = 8'h10; b_b = 8'h01;
        @(negedge clk);
        b_op = 4'b0011; b_a = 8'hAA; b_b = 8'h55;
        for (int k = 0; k < 2; k++) begin
            chk("t4_ready_exec", b_ir, 1'b0);
            @(negedge clk);
            chk("t4_alu_hold", {b_sel, b_aa, b_ab}, 20'h11001);
        end
        b_iv = 1'b0;
        for (int k = 0; k < 8 && !b_rv; k++) @(negedge clk);
        chk("t4_valid", b_rv, 1'b1);
        chk("t4_data", b_rd, 8'h0F);
        chk("t4_class", b_rc, 2'd0);
        chk("t4_count", b_cnt, 16'd2);

        // C: reset in the middle of EXEC discards the op.
        c_iv = 1'b1; c_op = 4'b0000; c_a = 8'h01; c_b = 8'h01;
        @(negedge clk);
        c_iv = 1'b0;
        @(negedge clk);
        chk("t5_busy_pre", c_busy, 1'b1);
        c_rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {c_rv, c_busy, c_sel, c_aa, c_ab, c_rd}, 38'h0);
        chk("t5_rst_count", c_cnt, 4'd0);
        @(negedge clk);
        c_rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | c_rv;
        end
        chk("t5_no_valid", seen, 1'b0);
        chk("t5_count", c_cnt, 4'd0);

        // C: 17 completed ops on a 4-bit counter.
        c_rr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) chk("t6_wrap_zero", c_cnt, 4'd0);
            c_iv = 1'b1; c_op = 4'(i); c_a = 8'(i); c_b = 8'h01;
            @(negedge clk);
            c_iv = 1'b0;
            for (int k = 0; k < 10 && !c_rv; k++) @(negedge clk);
            chk($sformatf("t6_valid_%0d", i), c_rv, 1'b1);
            @(negedge clk);
        end
        c_rr = 1'b0;
        chk("t6_wrap_count", c_cnt, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
